// File: rtl/vector_writeback_seq.sv
// Vector register writeback sequencer: turns one full-row writeback command
// into single-cell writes, one per clock, in ascending lane order.
module vector_writeback_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_row,
    input  logic [3:0]        in_lane_mask,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic              writeEnable,
    output logic [3:0]        writeAddressR,
    output logic [1:0]        writeAddressC,
    output logic [DATA_W-1:0] writeData,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state, stateNext;
    logic [3:0]              pendMask, pendMaskNext;
    logic [3:0]              rowReg, rowRegNext;
    logic [3:0][DATA_W-1:0]  laneData, laneDataNext;
    logic [3:0][DATA_W-1:0]  inLanes;
    logic                    weNext, doneNext;
    logic [3:0]              addrRNext;
    logic [1:0]              addrCNext, lane;
    logic [DATA_W-1:0]       dataNext;

    function automatic logic [1:0] lowestLane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign inLanes  = {in_data3, in_data2, in_data1, in_data0};
    assign busy     = (state == WRITE);
    // Gated by reset so the upstream never sees a ready while reset is held.
    assign in_ready = (state == IDLE) && reset;

    // Next-state and next-output logic; each write clears its lane from the
    // pending mask so done can be flagged alongside the final write.
    always_comb begin
        stateNext    = state;
        pendMaskNext = pendMask;
        rowRegNext   = rowReg;
        laneDataNext = laneData;
        weNext       = 1'b0;
        doneNext     = 1'b0;
        addrRNext    = writeAddressR;
        addrCNext    = writeAddressC;
        dataNext     = writeData;
        lane         = 2'd0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    rowRegNext   = in_row;
                    laneDataNext = inLanes;
                    if (in_lane_mask != 4'b0000) begin
                        lane         = lowestLane(in_lane_mask);
                        weNext       = 1'b1;
                        addrRNext    = in_row;
                        addrCNext    = lane;
                        dataNext     = inLanes[lane];
                        pendMaskNext = in_lane_mask & ~(4'b0001 << lane);
                        doneNext     = (pendMaskNext == 4'b0000);
                        stateNext    = WRITE;
                    end else begin
                        pendMaskNext = 4'b0000;
                        doneNext     = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (pendMask != 4'b0000) begin
                    lane         = lowestLane(pendMask);
                    weNext       = 1'b1;
                    addrRNext    = rowReg;
                    addrCNext    = lane;
                    dataNext     = laneData[lane];
                    pendMaskNext = pendMask & ~(4'b0001 << lane);
                    doneNext     = (pendMaskNext == 4'b0000);
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and registered outputs; reset discards any pending lanes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pendMask      <= '0;
            rowReg        <= '0;
            laneData      <= '0;
            writeEnable   <= 1'b0;
            writeAddressR <= '0;
            writeAddressC <= '0;
            writeData     <= '0;
            done          <= 1'b0;
        end else begin
            state         <= stateNext;
            pendMask      <= pendMaskNext;
            rowReg        <= rowRegNext;
            laneData      <= laneDataNext;
            writeEnable   <= weNext;
            writeAddressR <= addrRNext;
            writeAddressC <= addrCNext;
            writeData     <= dataNext;
            done          <= doneNext;
        end
    end

endmodule

// File: doc/vector_writeback_seq.md
VECTOR_WRITEBACK_SEQ -- requirements
Module: vector_writeback_seq

Interface
REQ-001 Parameter: DATA_W, 32, width of one vector-register cell.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  writeback command valid.
REQ-005 in_ready  output  1  block can accept a command.
REQ-006 in_row  input  4  destination vector-register row (0-15).
REQ-007 in_lane_mask  input  4  bit k set = write lane k.
REQ-008 in_data0, in_data1, in_data2, in_data3  input  DATA_W each  lane 0-3 payload.
REQ-009 writeEnable  output  1  cell-write strobe to the vector register set.
REQ-010 writeAddressR  output  4  row address of the cell write.
REQ-011 writeAddressC  output  2  lane address of the cell write.
REQ-012 writeData  output  DATA_W  cell write data.
REQ-013 busy  output  1  high while lane writes are pending or being issued.
REQ-014 done  output  1  one-cycle pulse on command completion.

Function
REQ-015 The block SHALL convert one full-row writeback command into a series of single-cell writes, one per clock, driving a register set that captures writeEnable/address/data on the rising edge.
REQ-016 The state machine SHALL have two states: IDLE and WRITE. busy = (state == WRITE).
REQ-017 in_ready SHALL be 1 in IDLE and 0 in WRITE. It SHALL be 0 while reset is asserted.
REQ-018 A command SHALL be accepted on a rising edge where in_valid = 1 and in_ready = 1. in_row, in_lane_mask and all four in_data lanes SHALL be captured on that edge. Inputs SHALL be ignored at all other times.
REQ-019 writeEnable, writeAddressR, writeAddressC, writeData and done SHALL be registered outputs.
REQ-020 Accept with nonzero mask:
  - state -> WRITE.
  - First write presented in the cycle after the accepting edge: lowest set mask lane, writeAddressR = captured row.
  - That lane SHALL be cleared from the pending mask.
REQ-021 In WRITE, each edge SHALL present the next-lowest pending lane.
  - Lanes are written in ascending order, with no idle cycles between writes.
  - Masked-off lanes are skipped and are never written.
REQ-022 done SHALL be 1 in the same cycle as the last writeEnable of a command.
REQ-023 On the edge that ends the last write: writeEnable -> 0, done -> 0, state -> IDLE, so in_ready = 1 in the following cycle.
REQ-024 Latency and throughput: a command with n set lanes (n = 1-4) SHALL give writeEnable high for exactly n consecutive cycles. in_ready SHALL be low for exactly n cycles after the accept, allowing back-to-back commands with one accept cycle between write bursts.
REQ-025 Accept with mask = 0: no write is issued, state stays IDLE, done pulses for one cycle after the accepting edge, and in_ready stays 1.
REQ-026 When writeEnable = 0, writeAddressR, writeAddressC and writeData SHALL hold their last values. Consumers SHALL qualify on writeEnable.
REQ-027 Row and lane values SHALL be passed through unmodified, with no wrap or arithmetic. Row 15 and lane 3 are legal.

Reset
REQ-028 While reset = 0, regardless of clock:
  - state = IDLE.
  - pending mask, captured row and captured data = 0.
  - writeEnable = 0, writeAddressR = 0, writeAddressC = 0, writeData = 0, done = 0, busy = 0, in_ready = 0.
REQ-029 Reset asserted mid-burst SHALL discard all remaining lane writes. No write SHALL be issued after reset release until a new command is accepted.
REQ-030 in_ready SHALL become 1 in the first cycle after reset deasserts.

Verification
REQ-031 Full mask: row 5, mask 4'b1111, data 10/11/12/13 -> writeEnable high 4 cycles; (R,C,data) = (5,0,10), (5,1,11), (5,2,12), (5,3,13); done with the 4th write; in_ready 0 for 4 cycles, then 1.
REQ-032 Sparse mask: row 15, mask 4'b1010, data3 = 32'hFFFFFFFF -> exactly 2 consecutive writes, (15,1,data1) then (15,3,32'hFFFFFFFF); lanes 0 and 2 never written.
REQ-033 Zero mask: mask 4'b0000 -> writeEnable never high; done pulses 1 cycle after accept; in_ready remains 1.
REQ-034 Back-to-back: cmd A (row 2, mask 4'b0001), then cmd B (row 3, mask 4'b1000) held valid -> B accepted on the first edge with in_ready = 1; writes (2,0,A0) then (3,3,B3); in_data changes while in_ready = 0 do not alter issued data.
REQ-035 Reset mid-burst: mask 4'b1111, assert reset after the 2nd write -> all outputs 0 immediately; no lane 2/3 writes after release; in_ready = 1 in the first cycle after release.
REQ-036 Integration: drive a 16x4 register set and read row 5 after REQ-031 -> lanes read 10, 11, 12, 13; other rows unchanged.
